// File: rtl/adc_scan_pkg.sv
// Shared types, widths and the code-to-millivolt conversion for the ADC channel scanner.
package adc_scan_pkg;

  localparam int unsigned RAW_W         = 12;
  localparam int unsigned MV_W          = 13;
  localparam int unsigned CH_W          = 5;
  localparam int unsigned SLOT_W        = 3;
  localparam int unsigned MAX_CH        = 8;
  localparam int unsigned ERR_W         = 8;
  localparam int unsigned ADC_FULL_CODE = 4095;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CONV
  } scan_state_e;

  // One result-bank write: slot index plus the averaged code and its millivolt value.
  typedef struct packed {
    logic [SLOT_W-1:0] slot;
    logic [RAW_W-1:0]  raw;
    logic [MV_W-1:0]   mv;
  } bank_wr_t;

  // floor(raw * fs_mv / 4095); the product needs 25 bits, 32 are used.
  function automatic logic [MV_W-1:0] raw_to_mv(input logic [RAW_W-1:0] raw,
                                                input int unsigned      fs_mv);
    logic [31:0] prod;
    prod = 32'(raw) * 32'(fs_mv);
    return MV_W'(prod / 32'(ADC_FULL_CODE));
  endfunction

endpackage

// File: rtl/adc_result_bank.sv
// Per-slot result register file: one write port, combinational read with read-clears-fresh.
module adc_result_bank
  import adc_scan_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              wr_en,
  input  bank_wr_t          wr,
  input  logic [SLOT_W-1:0] rd_sel,
  output logic [MV_W-1:0]   rd_mv,
  output logic [RAW_W-1:0]  rd_raw,
  output logic              rd_fresh
);

  // Storage is sized for the widest configuration; entries past NUM_CH are never written.
  logic [RAW_W-1:0] raw_q   [MAX_CH];
  logic [MV_W-1:0]  mv_q    [MAX_CH];
  logic             fresh_q [MAX_CH];

  // Write port; a pending read-clear of fresh loses to a write of the same slot.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_CH; i++) begin
        raw_q[i]   <= '0;
        mv_q[i]    <= '0;
        fresh_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < MAX_CH; i++) begin
        if (wr_en && (wr.slot == SLOT_W'(i))) begin
          raw_q[i]   <= wr.raw;
          mv_q[i]    <= wr.mv;
          fresh_q[i] <= 1'b1;
        end else if (rd_sel == SLOT_W'(i)) begin
          fresh_q[i] <= 1'b0;
        end
      end
    end
  end

  // Read port; out-of-range selects read as zero.
  always_comb begin
    rd_mv    = '0;
    rd_raw   = '0;
    rd_fresh = 1'b0;
    if (32'(rd_sel) < NUM_CH) begin
      rd_mv    = mv_q[rd_sel];
      rd_raw   = raw_q[rd_sel];
      rd_fresh = fresh_q[rd_sel];
    end
  end

endmodule

// File: rtl/adc_channel_scanner.sv
// Round-robin ADC scanner: block-averages samples per channel and banks the results in mV.
module adc_channel_scanner
  import adc_scan_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned FIRST_CH = 1,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned FS_MV    = 5000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              one_shot,
  output logic              cmd_valid,
  output logic [CH_W-1:0]   cmd_channel,
  input  logic              cmd_ready,
  input  logic              rsp_valid,
  input  logic [CH_W-1:0]   rsp_channel,
  input  logic [RAW_W-1:0]  rsp_data,
  input  logic [SLOT_W-1:0] rd_sel,
  output logic [MV_W-1:0]   rd_mv,
  output logic [RAW_W-1:0]  rd_raw,
  output logic              rd_fresh,
  output logic              upd_strobe,
  output logic [SLOT_W-1:0] upd_slot,
  output logic              pass_done,
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned ACC_W  = RAW_W + AVG_LOG2;
  localparam int unsigned SCNT_W = AVG_LOG2 + 1;
  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT   = SLOT_W'(NUM_CH - 1);
  localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX    = TCNT_W'(TIMEOUT);

  scan_state_e       state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [CH_W-1:0]   cur_ch;
  logic [RAW_W-1:0]  avg_c;
  logic              err_inc;
  logic              conv_c;
  logic              pass_c;
  bank_wr_t          wr_c;

  // Next-state, datapath next values and bank write request.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    acc_d   = acc_q;
    scnt_d  = scnt_q;
    tcnt_d  = tcnt_q;
    err_inc = 1'b0;
    conv_c  = 1'b0;
    pass_c  = 1'b0;
    cur_ch  = CH_W'(FIRST_CH) + CH_W'(slot_q);
    avg_c   = RAW_W'(acc_q >> AVG_LOG2);
    wr_c.slot = slot_q;
    wr_c.raw  = avg_c;
    wr_c.mv   = raw_to_mv(avg_c, FS_MV);

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_ISSUE;
          slot_d  = '0;
          scnt_d  = '0;
          acc_d   = '0;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          state_d = ST_WAIT;
          tcnt_d  = '0;
        end
      end
      ST_WAIT: begin
        tcnt_d = tcnt_q + TCNT_W'(1);
        if (rsp_valid && (rsp_channel == cur_ch)) begin
          acc_d   = acc_q + ACC_W'(rsp_data);
          scnt_d  = scnt_q + SCNT_W'(1);
          state_d = (scnt_q == LAST_SAMPLE) ? ST_CONV : ST_ISSUE;
        end else if (tcnt_q == TCNT_MAX) begin
          // Re-issue the same sample; the partial accumulation is kept.
          err_inc = 1'b1;
          state_d = ST_ISSUE;
        end else if (rsp_valid) begin
          err_inc = 1'b1;
        end
      end
      ST_CONV: begin
        conv_c = 1'b1;
        acc_d  = '0;
        scnt_d = '0;
        if (slot_q == LAST_SLOT) begin
          pass_c  = 1'b1;
          slot_d  = '0;
          state_d = (one_shot || !enable) ? ST_IDLE : ST_ISSUE;
        end else begin
          slot_d  = slot_q + SLOT_W'(1);
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      acc_q       <= '0;
      scnt_q      <= '0;
      tcnt_q      <= '0;
      cmd_valid   <= 1'b0;
      cmd_channel <= '0;
      upd_strobe  <= 1'b0;
      upd_slot    <= '0;
      pass_done   <= 1'b0;
      err_count   <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      acc_q      <= acc_d;
      scnt_q     <= scnt_d;
      tcnt_q     <= tcnt_d;
      cmd_valid  <= (state_d == ST_ISSUE);
      if (state_d == ST_ISSUE) begin
        cmd_channel <= CH_W'(FIRST_CH) + CH_W'(slot_d);
      end
      upd_strobe <= conv_c;
      if (conv_c) begin
        upd_slot <= slot_q;
      end
      pass_done  <= pass_c;
      if (err_inc && (err_count != '1)) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

  adc_result_bank #(
    .NUM_CH (NUM_CH)
  ) u_bank (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .wr_en    (conv_c),
    .wr       (wr_c),
    .rd_sel   (rd_sel),
    .rd_mv    (rd_mv),
    .rd_raw   (rd_raw),
    .rd_fresh (rd_fresh)
  );

endmodule

// File: tb/tb_adc_channel_scanner.sv
// Randomized bench for adc_channel_scanner with an ADC responder and a per-slot average model.
module tb_adc_channel_scanner;

  localparam int NUM_CH   = 4;
  localparam int FIRST_CH = 1;
  localparam int NSAMP    = 4;
  localparam int FS_MV    = 5000;
  localparam int TIMEOUT  = 255;

  logic        sys_clk = 1'b0;
  logic        reset, enable, one_shot;
  logic        cmd_valid, cmd_ready;
  logic [4:0]  cmd_channel, rsp_channel;
  logic        rsp_valid;
  logic [11:0] rsp_data, rd_raw;
  logic [2:0]  rd_sel, upd_slot;
  logic [12:0] rd_mv;
  logic        rd_fresh, upd_strobe, pass_done;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_err  = 0;
  int data_mode;
  int exp_raw [NUM_CH];
  int exp_mv  [NUM_CH];
  int mid_pat [NSAMP] = '{2046, 2048, 2050, 2048};

  always #5 sys_clk = ~sys_clk;

  adc_channel_scanner dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .enable      (enable),
    .one_shot    (one_shot),
    .cmd_valid   (cmd_valid),
    .cmd_channel (cmd_channel),
    .cmd_ready   (cmd_ready),
    .rsp_valid   (rsp_valid),
    .rsp_channel (rsp_channel),
    .rsp_data    (rsp_data),
    .rd_sel      (rd_sel),
    .rd_mv       (rd_mv),
    .rd_raw      (rd_raw),
    .rd_fresh    (rd_fresh),
    .upd_strobe  (upd_strobe),
    .upd_slot    (upd_slot),
    .pass_done   (pass_done),
    .err_count   (err_count)
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ADC sample value for a given slot and sample index in the current data mode.
  function automatic int gen_sample(input int slot, input int idx);
    if (data_mode == 0) return 4095;
    if (data_mode == 1 && slot == 0) return 0;
    if (data_mode == 1 && slot == 1) return mid_pat[idx];
    return int'($urandom_range(0, 4095));
  endfunction

  // Serve one full pass as the ADC and score it against the model.
  task automatic run_pass(input bit cont, input int stall, input bit drop_first,
                          input int wrong_slot, input int wrong_cmds, input int wrong_n,
                          input int en_drop_slot);
    int slot, cnt, sum, resp_cnt, wrong_left, drop_wait, cmds, passes, after, idle_bad;
    int budget, stall_bad, pend;
    bit awaiting, dropping, done;
    logic [4:0] stall_ch;
    int upd_q[$];
    int upd_cyc_q[$];
    slot = 0; cnt = 0; sum = 0; resp_cnt = 0; wrong_left = 0; drop_wait = 0; cmds = 0;
    passes = 0; after = 0; idle_bad = 0; budget = 0; stall_bad = 0;
    awaiting = 1'b0; dropping = 1'b0; done = 1'b0;
    one_shot = !cont;
    enable   = 1'b1;

    // Back-pressure the first command; a matching response meanwhile must be ignored.
    if (stall > 0) begin
      while (!cmd_valid && budget < 20) begin
        @(negedge sys_clk); cyc++; budget++;
      end
      stall_ch = cmd_channel;
      for (int i = 0; i < stall; i++) begin
        @(negedge sys_clk); cyc++;
        rsp_valid   = (i == 2);
        rsp_channel = 5'(FIRST_CH);
        rsp_data    = 12'($urandom_range(0, 4095));
        if (!cmd_valid || cmd_channel != stall_ch) stall_bad++;
      end
      check_eq("stall_hold", stall_bad, 0);
      check_eq("stall_channel", stall_ch, FIRST_CH);
    end

    budget = 0;
    while (!done) begin
      @(negedge sys_clk); cyc++; budget++;
      rsp_valid = 1'b0;
      cmd_ready = 1'b0;

      if (upd_strobe) begin
        if (upd_q.size() == 0) check_eq("upd_unexpected", 1, 0);
        else begin
          check_eq("upd_slot", upd_slot, upd_q.pop_front());
          check_eq("upd_latency", cyc - upd_cyc_q.pop_front(), 2);
        end
      end
      if (pass_done) begin
        passes++;
        check_eq("cmd_valid_at_pass", cmd_valid, 0);
        enable = 1'b0;
      end
      if (passes > 0) begin
        if (cmd_valid) idle_bad++;
        after++;
        if (after == 6) done = 1'b1;
      end

      if (dropping) begin
        if (cmd_valid) begin
          check_eq("timeout_gap", drop_wait, TIMEOUT + 1);
          dropping = 1'b0;
          awaiting = 1'b0;
        end else drop_wait++;
      end

      if (awaiting && resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          rsp_valid = 1'b1;
          if (wrong_left > 0) begin
            wrong_left--;
            rsp_channel = 5'd7;
            rsp_data    = 12'($urandom_range(0, 4095));
            exp_err++;
            resp_cnt = 1;
          end else begin
            pend        = gen_sample(slot, cnt);
            rsp_channel = 5'(FIRST_CH + slot);
            rsp_data    = 12'(pend);
            sum += pend;
            cnt++;
            awaiting = 1'b0;
            if (slot == en_drop_slot && cnt == 1) enable = 1'b0;
            if (cnt == NSAMP) begin
              exp_raw[slot] = sum / NSAMP;
              exp_mv[slot]  = exp_raw[slot] * FS_MV / 4095;
              upd_q.push_back(slot);
              upd_cyc_q.push_back(cyc);
              slot++; cnt = 0; sum = 0;
            end
          end
        end
      end else if (!awaiting && cmd_valid && passes == 0) begin
        cmd_ready = 1'b1;
        awaiting  = 1'b1;
        cmds++;
        check_eq("cmd_channel", cmd_channel, FIRST_CH + slot);
        if (drop_first && cmds == 1) begin
          dropping  = 1'b1;
          drop_wait = 0;
          exp_err++;
        end else begin
          resp_cnt   = 1 + int'($urandom_range(0, 3));
          wrong_left = (slot == wrong_slot && cnt < wrong_cmds) ? wrong_n : 0;
        end
      end

      if (budget > 4000) begin
        check_eq("pass_budget", budget, 0);
        done = 1'b1;
      end
    end

    check_eq("pass_count", passes, 1);
    check_eq("idle_after_pass", idle_bad, 0);
    check_eq("upd_pending", upd_q.size(), 0);
    check_eq("err_count", err_count, (exp_err > 255) ? 255 : exp_err);

    // Bank contents, fresh flag and its clear-after-read.
    for (int s = 0; s < NUM_CH; s++) begin
      rd_sel = 3'(s);
      #1;
      check_eq($sformatf("raw_slot%0d", s), rd_raw, exp_raw[s]);
      check_eq($sformatf("mv_slot%0d", s), rd_mv, exp_mv[s]);
      check_eq($sformatf("fresh_slot%0d", s), rd_fresh, 1);
      @(negedge sys_clk); cyc++;
      check_eq($sformatf("fresh_clr%0d", s), rd_fresh, 0);
    end
    rd_sel = 3'($urandom_range(NUM_CH, 7));
    #1;
    check_eq("oob_read", {rd_mv, rd_raw, rd_fresh}, 0);
    rd_sel = 3'd7;
  endtask

  initial begin
    int budget;
    reset = 1'b1; enable = 1'b0; one_shot = 1'b1; cmd_ready = 1'b0;
    rsp_valid = 1'b0; rsp_channel = '0; rsp_data = '0; rd_sel = '0;
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);
    check_eq("rst_cmd_valid", cmd_valid, 0);
    check_eq("rst_upd_pass", {upd_strobe, pass_done}, 0);
    check_eq("rst_err", err_count, 0);
    check_eq("rst_bank", {rd_mv, rd_raw, rd_fresh}, 0);
    rd_sel = 3'd7;

    data_mode = 0;
    run_pass(1'b0, 0, 1'b0, -1, 0, 0, -1);
    data_mode = 1;
    run_pass(1'b0, 0, 1'b0, -1, 0, 0, -1);
    rd_sel = 3'd1; #1;
    check_eq("mid_scale_mv", rd_mv, 2500);
    rd_sel = 3'd0; #1;
    check_eq("zero_mv", rd_mv, 0);
    rd_sel = 3'd7;
    data_mode = 2;
    run_pass(1'b0, 10, 1'b1, 2, 1, 1, -1);
    run_pass(1'b1, 0, 1'b0, -1, 0, 0, 2);
    run_pass(1'b0, 0, 1'b0, 0, 4, 80, -1);

    // Reset while waiting for a response; a late response in IDLE is ignored.
    enable = 1'b1; budget = 0;
    while (!cmd_valid && budget < 20) begin
      @(negedge sys_clk); budget++;
    end
    cmd_ready = 1'b1;
    @(negedge sys_clk);
    cmd_ready = 1'b0;
    check_eq("wait_cmd_valid", cmd_valid, 0);
    reset = 1'b1; enable = 1'b0; rd_sel = 3'd1;
    @(negedge sys_clk);
    reset = 1'b0;
    check_eq("mid_rst_outputs", {cmd_valid, upd_strobe, pass_done}, 0);
    check_eq("mid_rst_err", err_count, 0);
    check_eq("mid_rst_bank", {rd_mv, rd_raw, rd_fresh}, 0);
    rsp_valid = 1'b1; rsp_channel = 5'(FIRST_CH); rsp_data = 12'd4095;
    @(negedge sys_clk);
    rsp_valid = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_eq("late_rsp_err", err_count, 0);
    check_eq("late_rsp_idle", {cmd_valid, upd_strobe}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_channel_scanner.md
# adc_channel_scanner

Multi-channel successor to the single-channel ADC sample/convert path. It round-robins the modular ADC sequencer over `NUM_CH` consecutive channels and block-averages `2^AVG_LOG2` samples per channel. Each average is converted to millivolts and kept in a per-channel result bank for the game logic, HEX and LED drivers. It sits between `adc_qsys` (Avalon-ST command/response) and the consumers of `vol`.

## Interface
- `NUM_CH`, 4: channels scanned, 1..8.
- `FIRST_CH`, 1: ADC channel number of scan slot 0. Slot i maps to channel `FIRST_CH+i`.
- `AVG_LOG2`, 2: log2 of samples averaged per result, 0..4.
- `FS_MV`, 5000: millivolts at raw code 4095.
- `TIMEOUT`, 255: cycles to wait for a response before re-issuing, ≥ 8.
- `Clk` in 1: system clock (`sys_clk`).
- `reset` in 1: synchronous, active-high.
- `enable` in 1: scanning permitted.
- `one_shot` in 1: 1 = stop after one full pass; 0 = continuous.
- `cmd_valid` out 1, `cmd_channel` out 5, `cmd_ready` in 1: command to the ADC.
- `rsp_valid` in 1, `rsp_channel` in 5, `rsp_data` in 12: response from the ADC.
- `rd_sel` in 3: result bank read select (slot index).
- `rd_mv` out 13, `rd_raw` out 12, `rd_fresh` out 1: combinational read of the selected slot.
- `upd_strobe` out 1, `upd_slot` out 3: one-cycle pulse when a slot's result is written.
- `pass_done` out 1: one-cycle pulse at the end of each full pass.
- `err_count` out 8: saturating count of timeouts plus channel mismatches.

## Operation
- FSM states: IDLE → ISSUE → WAIT → (ISSUE | CONV) → (ISSUE | IDLE).
- **IDLE**
  - `enable=1` → ISSUE with slot=0 and sample counter=0.
  - `cmd_valid=0`.
- **ISSUE**
  - Drives `cmd_valid=1` and `cmd_channel=FIRST_CH+slot`.
  - Goes to WAIT on the cycle `cmd_valid & cmd_ready`.
- **WAIT**
  - `cmd_valid=0` and the timeout counter runs. Exactly one command is outstanding at a time.
  - On `rsp_valid` with `rsp_channel == FIRST_CH+slot`: accumulate `rsp_data`, increment the sample counter.
    - If the counter reaches `2^AVG_LOG2`, go to CONV.
    - Otherwise go back to ISSUE.
  - On `rsp_valid` with a mismatched channel: discard, `err_count++`, stay in WAIT, keep the timeout counter running.
  - On timeout counter = `TIMEOUT`: `err_count++`, go to ISSUE for the same sample; the accumulator is kept.
- **CONV** (one cycle)
  - `avg = acc >> AVG_LOG2`.
  - `mv = floor(avg*FS_MV/4095)`, computed with at least 25-bit intermediates and truncated.
  - Write `raw[slot]=avg`, `mv[slot]=mv`, set `fresh[slot]`, pulse `upd_strobe`/`upd_slot`.
  - Clear the accumulator and sample counter.
  - If slot = `NUM_CH-1`: pulse `pass_done` and set slot=0.
    - Go to IDLE if `one_shot=1` or `enable=0`.
    - Otherwise go to ISSUE.
  - If slot < `NUM_CH-1`: slot++ and go to ISSUE.
- `enable` deasserting mid-pass does not abort. The current pass completes, then the FSM goes to IDLE.
- `fresh[slot]` clears on the cycle after it is read via `rd_sel`, unless CONV writes that same slot in the same cycle; the write wins.
- `rd_sel ≥ NUM_CH` returns 0 on all read outputs.
- `err_count` saturates at 255.

## Timing
- Reset (synchronous):
  - FSM = IDLE; slot, accumulator, sample counter and timeout counter = 0.
  - All bank entries: mv/raw = 0, fresh = 0.
  - `cmd_valid`, `upd_strobe`, `pass_done` = 0; `err_count` = 0.
  - Reset mid-transaction: a response arriving afterwards in IDLE is ignored and is not counted as an error.
- A response is accepted in WAIT only; `rsp_valid` in any other state is ignored.
- The final response of a slot is followed by CONV on the next cycle. Bank and `upd_strobe` are visible 2 cycles after that `rsp_valid` edge.
- `cmd_channel` holds stable while `cmd_valid=1` and `cmd_ready=0`.
- The cycle count from the ISSUE handshake to the timeout re-issue is exactly `TIMEOUT+1`.

## Structure
- Shared package `adc_scan_pkg`:
  - FSM state enum.
  - `ADC_FULL_CODE = 4095` and raw/mV width constants.
  - Conversion helper function.
- One sub-module `adc_result_bank`: `NUM_CH`-entry register file holding raw/mv/fresh, with one write port and the combinational `rd_sel` read.

## Test plan
- Defaults, ADC model returning 4095 on all channels, `enable=1`, `one_shot=1`:
  - Commands go to channels 1,2,3,4, 4 samples each.
  - All slots hold mv = 5000, raw = 4095.
  - One `pass_done` pulse, then IDLE.
- Samples 2046, 2048, 2050, 2048 on channel 2 (avg 2048) → `rd_mv` = 2500 for slot 1; raw 0 → 0 mV.
- `cmd_ready` held low for 10 cycles → `cmd_valid` and `cmd_channel` stay stable; no response is consumed.
- Response dropped for the first command → re-issue after `TIMEOUT+1` = 256 cycles; `err_count` = 1; final result unchanged.
- Response on channel 7 while waiting on channel 3 → discarded, `err_count` +1, then the correct response is accepted.
- Continuous mode with `enable` dropped mid-slot 2 → slots 2 and 3 complete, `pass_done` fires, then IDLE. Reset asserted during WAIT → all outputs return to reset values on the next cycle.
